cpu_dbus_guard: RTL
===================

# cpu_dbus_guard

Data-bus gatekeeper between the CPU data port and the memory bus. It is the consumer of the MPU verdict. Each CPU data request is checked against `access_deny` in the request cycle. Permitted requests are forwarded to memory and the response is returned to the CPU. Denied requests, and memory accesses that time out, become a fault pulse, with the fault address and cause captured for the trap handler.

## Interface
- `TIMEOUT`, 255: cycles to wait for `mem_ack` before declaring a bus-timeout fault (1..65535).
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cpud_request`  in  1  one-cycle request pulse from CPU.
- `cpud_write`  in  1  1 = write, 0 = read.
- `cpud_addr`  in  32  byte address.
- `cpud_wdata`  in  32  write data.
- `cpud_wmask`  in  4  byte enables.
- `access_deny`  in  1  MPU verdict, valid combinationally in the same cycle as `cpud_request`.
- `cpud_ack`  out  1  one-cycle completion pulse.
- `cpud_rdata`  out  32  read data; valid with `cpud_ack` for reads, held afterwards.
- `cpud_fault`  out  1  one-cycle fault pulse (replaces `cpud_ack` for that request).
- `mem_request`  out  1  one-cycle request pulse to memory.
- `mem_write`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/32/32/4  registered copies of the CPU request, held until the next accepted request.
- `mem_ack`  in  1  memory completion pulse.
- `mem_rdata`  in  32  memory read data, valid with `mem_ack`.
- `fault_clear`  in  1  pulse; re-arms fault capture.
- `fault_valid`  out  1  sticky: a fault has been captured.
- `fault_addr`  out  32  address of the first fault since the last clear.
- `fault_cause`  out  2  cause of the first fault: 01 = MPU read deny, 10 = MPU write deny, 11 = bus timeout.
- `fault_count`  out  16  saturating count of all faults.
- `overrun`  out  1  sticky: a request arrived while busy; cleared by `fault_clear`.

## Operation
- States: IDLE and WAIT_MEM.
- IDLE, `cpud_request` with `access_deny` = 1:
  - next cycle, `cpud_fault` = 1;
  - state stays IDLE;
  - no `mem_request` is issued;
  - cause is 01 if `cpud_write` = 0, else 10.
- IDLE, `cpud_request` with `access_deny` = 0:
  - latch write/addr/wdata/wmask onto the `mem_*` outputs;
  - next cycle, `mem_request` = 1 and state becomes WAIT_MEM;
  - the timeout counter loads 0.
- WAIT_MEM, `mem_ack` = 1:
  - next cycle, `cpud_ack` = 1;
  - if the access was a read, `cpud_rdata` <= `mem_rdata`; writes leave `cpud_rdata` unchanged;
  - state returns to IDLE.
- WAIT_MEM, no ack:
  - the counter increments each cycle;
  - when the counter reaches `TIMEOUT`, the next cycle gives `cpud_fault` = 1 with cause 11, and state returns to IDLE.
  - A `mem_ack` arriving afterwards in IDLE is ignored.
- WAIT_MEM, `mem_ack` in the same cycle as counter == `TIMEOUT`: the ack wins, and no fault is raised.
- `cpud_request` in WAIT_MEM: the request is dropped and `overrun` is set. The CPU contract is one outstanding request.
- Fault capture:
  - On every fault, `fault_count` increments, saturating at 16'hFFFF.
  - If `fault_valid` = 0, load `fault_addr` and `fault_cause` and set `fault_valid`.
  - If `fault_valid` = 1, the first fault's address and cause are retained.
- `fault_clear` clears `fault_valid`, `fault_addr`, `fault_cause` and `overrun`; `fault_count` is not cleared.
  - If a fault is captured in the same cycle as `fault_clear`, the new fault is loaded and `fault_valid` ends at 1.
- Reset clears to 0:
  - state to IDLE;
  - all pulses;
  - `mem_*` outputs and `cpud_rdata`;
  - all fault registers, `overrun` and the timeout counter.
- A transaction in flight at reset is abandoned; no ack or fault is generated for it.

## Timing
- Denied request at cycle T: `cpud_fault` at T+1. A new request is accepted at T+1.
- Permitted request at T:
  - `mem_request` at T+1;
  - the earliest accepted `mem_ack` is at T+1;
  - `cpud_ack` one cycle after `mem_ack`, so at T+2 at minimum.
- Back-to-back: a request is accepted in the same cycle that `cpud_ack` is high, because state is already IDLE.
- Timeout with `mem_request` at T+1: the counter reaches `TIMEOUT` at T+1+`TIMEOUT`, and `cpud_fault` is at T+2+`TIMEOUT`.
- `cpud_ack` and `cpud_fault` are never high in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Permitted read to 0x0000_1000, `mem_ack` 3 cycles after `mem_request` with rdata 0xDEADBEEF: `mem_addr` = 0x1000, one `cpud_ack` with `cpud_rdata` = 0xDEADBEEF, `fault_count` = 0.
- Denied write to 0x0004_0010: `cpud_fault` at T+1, no `mem_request`, `fault_addr` = 0x0004_0010, `fault_cause` = 10, `fault_valid` = 1. Follow with a denied read to 0x8: `fault_addr` stays 0x0004_0010, `fault_count` = 2.
- `TIMEOUT` = 4 with no `mem_ack`: `cpud_fault` 6 cycles after the request, cause 11. A late `mem_ack` afterwards produces no `cpud_ack`.
- `mem_ack` in the exact cycle the counter reaches `TIMEOUT`: `cpud_ack` only, no fault.
- Second `cpud_request` while in WAIT_MEM: dropped, `overrun` = 1, only one `mem_request`. Then `fault_clear` together with a denied read to 0x20: `fault_valid` = 1, `fault_addr` = 0x20, `overrun` = 0.
- Reset asserted mid-WAIT_MEM, then a `mem_ack`: no `cpud_ack`, all outputs 0. Afterwards a fresh permitted write completes normally.

Source files
------------

// File: rtl/cpu_dbus_guard.sv
// CPU data-bus gatekeeper: applies the MPU verdict, forwards permitted accesses,
// times out stalled memory accesses and records fault address/cause/count.
module cpu_dbus_guard #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpud_request,
    input  logic        cpud_write,
    input  logic [31:0] cpud_addr,
    input  logic [31:0] cpud_wdata,
    input  logic [3:0]  cpud_wmask,
    input  logic        access_deny,
    output logic        cpud_ack,
    output logic [31:0] cpud_rdata,
    output logic        cpud_fault,
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        fault_clear,
    output logic        fault_valid,
    output logic [31:0] fault_addr,
    output logic [1:0]  fault_cause,
    output logic [15:0] fault_count,
    output logic        overrun
);
    localparam int unsigned CW = 16;

    typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mem_request_n, mem_write_n, cpud_ack_n, cpud_fault_n;
    logic [31:0]   mem_addr_n, mem_wdata_n, cpud_rdata_n, fault_addr_n;
    logic [3:0]    mem_wmask_n;
    logic          fault_valid_n, overrun_n;
    logic [1:0]    fault_cause_n;
    logic [15:0]   fault_count_n;
    logic          ev;
    logic [31:0]   ev_addr;
    logic [1:0]    ev_cause;

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_request <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            cpud_ack    <= 1'b0;
            cpud_rdata  <= '0;
            cpud_fault  <= 1'b0;
            fault_valid <= 1'b0;
            fault_addr  <= '0;
            fault_cause <= '0;
            fault_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mem_request <= mem_request_n;
            mem_write   <= mem_write_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            mem_wmask   <= mem_wmask_n;
            cpud_ack    <= cpud_ack_n;
            cpud_rdata  <= cpud_rdata_n;
            cpud_fault  <= cpud_fault_n;
            fault_valid <= fault_valid_n;
            fault_addr  <= fault_addr_n;
            fault_cause <= fault_cause_n;
            fault_count <= fault_count_n;
            overrun     <= overrun_n;
        end
    end

    // Next-state, transaction handling and fault capture
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        mem_request_n = 1'b0;
        mem_write_n   = mem_write;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        mem_wmask_n   = mem_wmask;
        cpud_ack_n    = 1'b0;
        cpud_rdata_n  = cpud_rdata;
        cpud_fault_n  = 1'b0;
        fault_valid_n = fault_valid;
        fault_addr_n  = fault_addr;
        fault_cause_n = fault_cause;
        fault_count_n = fault_count;
        overrun_n     = overrun;
        ev            = 1'b0;
        ev_addr       = '0;
        ev_cause      = '0;

        if (fault_clear) begin
            fault_valid_n = 1'b0;
            fault_addr_n  = '0;
            fault_cause_n = '0;
            overrun_n     = 1'b0;
        end

        case (state)
            IDLE: begin
                if (cpud_request) begin
                    if (access_deny) begin
                        ev       = 1'b1;
                        ev_addr  = cpud_addr;
                        ev_cause = cpud_write ? 2'b10 : 2'b01;
                    end else begin
                        mem_write_n   = cpud_write;
                        mem_addr_n    = cpud_addr;
                        mem_wdata_n   = cpud_wdata;
                        mem_wmask_n   = cpud_wmask;
                        mem_request_n = 1'b1;
                        cnt_n         = '0;
                        state_n       = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (cpud_request) overrun_n = 1'b1;
                // An ack in the timeout cycle still completes the access
                if (mem_ack) begin
                    cpud_ack_n = 1'b1;
                    if (!mem_write) cpud_rdata_n = mem_rdata;
                    state_n = IDLE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    ev       = 1'b1;
                    ev_addr  = mem_addr;
                    ev_cause = 2'b11;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (ev) begin
            cpud_fault_n = 1'b1;
            if (fault_count != 16'hFFFF) fault_count_n = fault_count + 16'd1;
            if (!fault_valid || fault_clear) begin
                fault_valid_n = 1'b1;
                fault_addr_n  = ev_addr;
                fault_cause_n = ev_cause;
            end
        end
    end
endmodule
